// File: rtl/tx_fmt_pkg.sv
// Shared constants for the UART line formatter: ASCII codes, FSM state encoding
// and the BCD-nibble-to-ASCII helper.
package tx_fmt_pkg;

  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_QMARK = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SIGN  = 3'd2,
    S_DIGIT = 3'd3,
    S_CR    = 3'd4,
    S_LF    = 3'd5
  } tx_state_e;

  // Valid BCD nibbles map to '0'..'9'; anything above 9 is flagged as '?'.
  function automatic logic [7:0] digit_ascii(input logic [3:0] nib);
    return (nib > 4'd9) ? ASC_QMARK : (ASC_ZERO + {4'h0, nib});
  endfunction

endpackage

// File: rtl/tx_fmt_fifo.sv
// Pending-line queue. When full, a push with no simultaneous pop overwrites the
// newest entry so the latest value always survives, and flags overflow.
module tx_fmt_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             overflow_q;
  logic             full, do_push, do_pop, do_over;

  assign empty    = (count_q == '0);
  assign full     = (count_q == LW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign do_over  = push && full && !do_pop;
  assign rdata    = mem_q[rd_ptr_q];
  assign level    = count_q;
  assign overflow = overflow_q;

  // Storage: no reset needed, validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end else if (do_over) begin
      mem_q[wr_ptr_q - AW'(1)] <= wdata;
    end
  end

  // Pointers, occupancy and the registered overflow pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= do_over;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tx_line_formatter.sv
// Turns every change of the signed BCD amount into one ASCII line for uart_tx:
// sign, DIGITS digits, then CR LF (or LF only). Changes are queued in a FIFO and
// each line is sent from a snapshot, so digits never mix between values.
// Optional feature macro: TX_FMT_LZ_BLANK_EN (leading zeros sent as spaces).
module tx_line_formatter
  import tx_fmt_pkg::*;
#(
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned EOL_CRLF   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        give_change,
  input  logic [4*DIGITS-1:0]         amount_bcd,
  input  logic                        tx_ready,
  output logic                        tx_dv,
  output logic [7:0]                  tx_byte,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int unsigned VAL_W = 1 + 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DIGITS) + 1;

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] dig_q, dig_d;
  logic [VAL_W-1:0] line_q, prev_val_q, cur_val, fifo_rdata;
  logic             prev_tx_ready_q, adv, push, pop, fifo_empty, blank;
  logic [3:0]       cur_nib;

  assign cur_val = {give_change, amount_bcd};
  assign push    = (cur_val != prev_val_q);
  // uart_tx drops tx_ready the cycle after it takes a byte; that edge means "sent".
  assign adv     = prev_tx_ready_q && !tx_ready;
  assign busy    = (state_q != S_IDLE) || !fifo_empty;

  tx_fmt_fifo #(
    .WIDTH (VAL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wdata    (cur_val),
    .rdata    (fifo_rdata),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .overflow (overflow)
  );

  // Change detect: tracks inputs even in reset, so reset alone never queues a line.
  always_ff @(posedge clk) begin
    prev_val_q <= cur_val;
  end

  // State, digit index, line snapshot and tx_ready history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      dig_q           <= '0;
      line_q          <= '0;
      prev_tx_ready_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      dig_q           <= dig_d;
      prev_tx_ready_q <= tx_ready;
      if (state_q == S_LOAD) line_q <= fifo_rdata;
    end
  end

  // Next-state logic; the FIFO head is popped during the single LOAD cycle.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_LOAD;
      S_LOAD: begin
        pop     = 1'b1;
        state_d = S_SIGN;
      end
      S_SIGN: if (adv) begin
        state_d = S_DIGIT;
        dig_d   = CNT_W'(DIGITS - 1);
      end
      S_DIGIT: if (adv) begin
        if (dig_q == '0) state_d = (EOL_CRLF != 0) ? S_CR : S_LF;
        else             dig_d   = dig_q - CNT_W'(1);
      end
      S_CR: if (adv) state_d = S_LF;
      S_LF: if (adv) state_d = fifo_empty ? S_IDLE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Select the nibble addressed by the digit index (index 0 is the last digit).
  always_comb begin
    cur_nib = 4'h0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (dig_q == CNT_W'(i)) cur_nib = line_q[4*i +: 4];
    end
  end

`ifdef TX_FMT_LZ_BLANK_EN
  // Blank a zero digit while every more-significant digit is also zero; never the last one.
  always_comb begin
    blank = (cur_nib == 4'h0) && (dig_q != '0);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((CNT_W'(i) > dig_q) && (line_q[4*i +: 4] != 4'h0)) blank = 1'b0;
    end
  end
`else
  // All digits are sent numerically.
  always_comb begin
    blank = 1'b0;
  end
`endif

  // Byte mux: driven only from the state and the snapshot, never from live inputs.
  always_comb begin
    tx_byte = 8'h00;
    tx_dv   = 1'b0;
    unique case (state_q)
      S_SIGN: begin
        tx_byte = line_q[VAL_W-1] ? ASC_MINUS : ASC_PLUS;
        tx_dv   = tx_ready;
      end
      S_DIGIT: begin
        tx_byte = blank ? ASC_SPACE : digit_ascii(cur_nib);
        tx_dv   = tx_ready;
      end
      S_CR: begin
        tx_byte = ASC_CR;
        tx_dv   = tx_ready;
      end
      S_LF: begin
        tx_byte = ASC_LF;
        tx_dv   = tx_ready;
      end
      default: begin
        tx_byte = 8'h00;
        tx_dv   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_line_formatter.sv
// Directed bench for tx_line_formatter: a default instance (3 digits, CR LF) and
// a 4-digit LF-only instance, each with a uart_tx model that takes a byte on
// tx_dv && tx_ready and then holds tx_ready low for 10 cycles.
module tb_tx_line_formatter;

`ifdef TX_FMT_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        gc_a, rdy_a, dv_a, busy_a, ovf_a;
  logic [11:0] amt_a;
  logic [7:0]  byte_a;
  logic [2:0]  lvl_a;
  logic        gc_b, rdy_b, dv_b, busy_b, ovf_b;
  logic [15:0] amt_b;
  logic [7:0]  byte_b;
  logic [2:0]  lvl_b;

  logic       stall = 1'b0;
  int         hold_a = 0, hold_b = 0, ov_cnt = 0;
  logic [7:0] cap_a[$];
  logic [7:0] cap_b[$];
  int         tests = 0, fails = 0;

  tx_line_formatter #(.DIGITS(3), .FIFO_DEPTH(4), .EOL_CRLF(1)) dut_a (
    .clk(clk), .reset(reset), .give_change(gc_a), .amount_bcd(amt_a), .tx_ready(rdy_a),
    .tx_dv(dv_a), .tx_byte(byte_a), .busy(busy_a), .fifo_level(lvl_a), .overflow(ovf_a)
  );

  tx_line_formatter #(.DIGITS(4), .FIFO_DEPTH(4), .EOL_CRLF(0)) dut_b (
    .clk(clk), .reset(reset), .give_change(gc_b), .amount_bcd(amt_b), .tx_ready(rdy_b),
    .tx_dv(dv_b), .tx_byte(byte_b), .busy(busy_b), .fifo_level(lvl_b), .overflow(ovf_b)
  );

  assign rdy_a = !stall && (hold_a == 0);
  assign rdy_b = (hold_b == 0);

  always @(posedge clk) begin
    if (reset) hold_a <= 0;
    else if (dv_a && rdy_a) begin
      cap_a.push_back(byte_a);
      hold_a <= 10;
    end else if (hold_a > 0) hold_a <= hold_a - 1;
  end

  always @(posedge clk) begin
    if (reset) hold_b <= 0;
    else if (dv_b && rdy_b) begin
      cap_b.push_back(byte_b);
      hold_b <= 10;
    end else if (hold_b > 0) hold_b <= hold_b - 1;
  end

  always @(posedge clk) if (ovf_a) ov_cnt <= ov_cnt + 1;

  function automatic logic [7:0] cap_at(input bit sel_b, input int idx);
    if (sel_b) return (idx < cap_b.size()) ? cap_b[idx] : 8'hxx;
    return (idx < cap_a.size()) ? cap_a[idx] : 8'hxx;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cap(input bit sel_b, input int target, input string name);
    int budget = 3000;
    while (((sel_b ? cap_b.size() : cap_a.size()) < target) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    tests++;
    if (budget == 0) begin
      fails++;
      $display("FAIL %s timeout: bytes=%0d want=%0d", name,
               sel_b ? cap_b.size() : cap_a.size(), target);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0;
    gc_a = 1'b0; amt_a = 12'h000; gc_b = 1'b0; amt_b = 16'h0000;
    cycles(3);
    reset = 1'b0;
    tests += 6;
    if (dv_a !== 1'b0)     begin fails++; $display("FAIL reset tx_dv: got %b want 0", dv_a); end
    if (byte_a !== 8'h00)  begin fails++; $display("FAIL reset tx_byte: got %02h want 00", byte_a); end
    if (busy_a !== 1'b0)   begin fails++; $display("FAIL reset busy: got %b want 0", busy_a); end
    if (lvl_a !== 3'd0)    begin fails++; $display("FAIL reset level: got %0d want 0", lvl_a); end
    if (ovf_a !== 1'b0)    begin fails++; $display("FAIL reset overflow: got %b want 0", ovf_a); end
    if (busy_b !== 1'b0)   begin fails++; $display("FAIL reset busy_b: got %b want 0", busy_b); end
    cycles(20);
    tests += 2;
    if (cap_a.size() != 0) begin fails++; $display("FAIL reset no_line_a: got %0d bytes want 0", cap_a.size()); end
    if (cap_b.size() != 0) begin fails++; $display("FAIL reset no_line_b: got %0d bytes want 0", cap_b.size()); end
  endtask

  task automatic test_single_line;
    logic [7:0] exp [6];
    int start = cap_a.size();
    exp = '{8'h2B, LZ ? 8'h20 : 8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A};
    amt_a = 12'h042;
    wait_cap(1'b0, start + 6, "single");
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (cap_at(1'b0, start + i) !== exp[i]) begin
        fails++;
        $display("FAIL single byte%0d: got %02h want %02h", i, cap_at(1'b0, start + i), exp[i]);
      end
    end
    cycles(3);
    tests++;
    if (busy_a !== 1'b0) begin fails++; $display("FAIL single busy_end: got %b want 0", busy_a); end
  endtask

  task automatic test_snapshot;
    logic [7:0] exp [12];
    int start = cap_a.size();
    exp = '{8'h2B, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A, 8'h2B, 8'h31, 8'h39, 8'h39, 8'h0D, 8'h0A};
    amt_a = 12'h123;
    wait_cap(1'b0, start + 2, "snapshot_mid");
    amt_a = 12'h199;
    wait_cap(1'b0, start + 12, "snapshot");
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cap_at(1'b0, start + i) !== exp[i]) begin
        fails++;
        $display("FAIL snapshot byte%0d: got %02h want %02h", i, cap_at(1'b0, start + i), exp[i]);
      end
    end
    cycles(3);
    tests++;
    if (busy_a !== 1'b0) begin fails++; $display("FAIL snapshot busy_end: got %b want 0", busy_a); end
  endtask

  task automatic test_sign_invalid;
    logic [7:0] exp [6];
    int start = cap_a.size();
    exp = '{8'h2D, LZ ? 8'h20 : 8'h30, 8'h3F, 8'h35, 8'h0D, 8'h0A};
    gc_a = 1'b1; amt_a = 12'h0A5;
    wait_cap(1'b0, start + 6, "sign");
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (cap_at(1'b0, start + i) !== exp[i]) begin
        fails++;
        $display("FAIL sign byte%0d: got %02h want %02h", i, cap_at(1'b0, start + i), exp[i]);
      end
    end
    cycles(3);
  endtask

  task automatic test_overflow;
    logic [7:0] exp [6];
    int start, ov0;
    exp = '{8'h2B, 8'h33, 8'h30, 8'h36, 8'h0D, 8'h0A};
    stall = 1'b1;
    cycles(3);
    start = cap_a.size();
    gc_a = 1'b0; amt_a = 12'h300;
    cycles(4);
    tests += 3;
    if (lvl_a !== 3'd0)  begin fails++; $display("FAIL ovf loaded_level: got %0d want 0", lvl_a); end
    if (busy_a !== 1'b1) begin fails++; $display("FAIL ovf stalled_busy: got %b want 1", busy_a); end
    if (dv_a !== 1'b0)   begin fails++; $display("FAIL ovf stalled_dv: got %b want 0", dv_a); end
    ov0 = ov_cnt;
    for (int i = 1; i <= 6; i++) begin
      amt_a = 12'h300 + 12'(i);
      cycles(1);
    end
    cycles(3);
    tests += 2;
    if (ov_cnt - ov0 != 2) begin fails++; $display("FAIL ovf pulses: got %0d want 2", ov_cnt - ov0); end
    if (lvl_a !== 3'd4)    begin fails++; $display("FAIL ovf level: got %0d want 4", lvl_a); end
    stall = 1'b0;
    wait_cap(1'b0, start + 30, "ovf_drain");
    tests += 4;
    if (cap_at(1'b0, start + 3) !== 8'h30)  begin fails++; $display("FAIL ovf line0: got %02h want 30", cap_at(1'b0, start + 3)); end
    if (cap_at(1'b0, start + 9) !== 8'h31)  begin fails++; $display("FAIL ovf line1: got %02h want 31", cap_at(1'b0, start + 9)); end
    if (cap_at(1'b0, start + 15) !== 8'h32) begin fails++; $display("FAIL ovf line2: got %02h want 32", cap_at(1'b0, start + 15)); end
    if (cap_at(1'b0, start + 21) !== 8'h33) begin fails++; $display("FAIL ovf line3: got %02h want 33", cap_at(1'b0, start + 21)); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (cap_at(1'b0, start + 24 + i) !== exp[i]) begin
        fails++;
        $display("FAIL ovf last byte%0d: got %02h want %02h", i, cap_at(1'b0, start + 24 + i), exp[i]);
      end
    end
    cycles(3);
    tests += 2;
    if (busy_a !== 1'b0)          begin fails++; $display("FAIL ovf busy_end: got %b want 0", busy_a); end
    if (cap_a.size() != start + 30) begin fails++; $display("FAIL ovf extra: got %0d bytes want %0d", cap_a.size(), start + 30); end
  endtask

  task automatic test_reset_mid_line;
    logic [7:0] exp [6];
    int start = cap_a.size();
    int s2;
    exp = '{8'h2B, 8'h34, 8'h35, 8'h38, 8'h0D, 8'h0A};
    amt_a = 12'h456;
    wait_cap(1'b0, start + 2, "rstmid_start");
    amt_a = 12'h457;
    cycles(1);
    reset = 1'b1;
    cycles(1);
    tests += 3;
    if (dv_a !== 1'b0)   begin fails++; $display("FAIL rstmid tx_dv: got %b want 0", dv_a); end
    if (lvl_a !== 3'd0)  begin fails++; $display("FAIL rstmid level: got %0d want 0", lvl_a); end
    if (busy_a !== 1'b0) begin fails++; $display("FAIL rstmid busy: got %b want 0", busy_a); end
    reset = 1'b0;
    s2 = cap_a.size();
    cycles(40);
    tests++;
    if (cap_a.size() != s2) begin fails++; $display("FAIL rstmid quiet: got %0d bytes want %0d", cap_a.size(), s2); end
    amt_a = 12'h458;
    wait_cap(1'b0, s2 + 6, "rstmid_new");
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (cap_at(1'b0, s2 + i) !== exp[i]) begin
        fails++;
        $display("FAIL rstmid byte%0d: got %02h want %02h", i, cap_at(1'b0, s2 + i), exp[i]);
      end
    end
    cycles(3);
  endtask

  task automatic test_sweep;
    logic [7:0] exp [6];
    int start = cap_b.size();
    exp = LZ ? '{8'h2B, 8'h20, 8'h20, 8'h20, 8'h37, 8'h0A}
             : '{8'h2B, 8'h30, 8'h30, 8'h30, 8'h37, 8'h0A};
    amt_b = 16'h0007;
    wait_cap(1'b1, start + 6, "sweep");
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (cap_at(1'b1, start + i) !== exp[i]) begin
        fails++;
        $display("FAIL sweep byte%0d: got %02h want %02h", i, cap_at(1'b1, start + i), exp[i]);
      end
    end
    cycles(3);
    tests += 2;
    if (busy_b !== 1'b0) begin fails++; $display("FAIL sweep busy_end: got %b want 0", busy_b); end
    if (cap_b.size() != start + 6) begin fails++; $display("FAIL sweep length: got %0d want %0d", cap_b.size(), start + 6); end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_snapshot();
    test_sign_invalid();
    test_overflow();
    test_reset_mid_line();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
